sc_environment_scanner: RTL
===========================

// Module: sc_environment_scanner
// PURPOSE
//  Reader end of the 8-row environment shift register: snapshots the eight 8-bit row buses once per
//  frame and scans them onto an 8x8 LED matrix, one row at a time. Row select is one-hot active-low,
//  and each row has a blanking gap before it is shown. Sits between the environment register and
//  the board matrix pins; frameStart tells the game logic when a snapshot has been taken.
// PARAMETERS
//  DATAWIDTH     8     width of each row bus and of col_OutBUS
//  DWELL_CYCLES  2500  clocks each row is driven (>=1)
//  BLANK_CYCLES  50    clocks all rows are off before each row is shown, for ghost suppression (>=1)
// PORTS
//  SC_ENVIRONMENT_SCANNER_CLOCK_50        in   1  system clock, rising edge
//  SC_ENVIRONMENT_SCANNER_RESET_InLow     in   1  asynchronous reset, active-low
//  SC_ENVIRONMENT_SCANNER_enable_InLow    in   1  0 = scan, 1 = idle with display dark
//  SC_ENVIRONMENT_SCANNER_data7..0_InBUS  in   8  row buses; data7 = top row
//  SC_ENVIRONMENT_SCANNER_row_OutBUS      out  8  one-hot active-low row select; bit k = data k
//  SC_ENVIRONMENT_SCANNER_col_OutBUS      out  8  column pattern of the selected row
//  SC_ENVIRONMENT_SCANNER_frameStart_Out  out  1  one-cycle high pulse when the snapshot is taken
// BEHAVIOUR
//  - One clock, CLOCK_50. Reset is asynchronous and active-low (RESET_InLow); nothing else is reset-sensitive.
//  - Reset values: state IDLE, row_OutBUS=8'hFF, col_OutBUS=8'h00, frameStart_Out=0,
//    shadow rows=0, row index=7, timer=0. All outputs are registered.
//  - FSM states: IDLE, LATCH, BLANK, SHOW.
//  - IDLE: outputs are dark (row=FF, col=00). If enable_InLow is sampled 0, go to LATCH next cycle.
//  - LATCH (1 cycle):
//    - copy data7..0 into shadow[7..0];
//    - set row index = 7;
//    - frameStart_Out=1 for this cycle only;
//    - go to BLANK.
//  - BLANK: row=FF; col=shadow[idx]. The timer loads BLANK_CYCLES-1 on entry and counts down.
//    At 0, go to SHOW.
//  - SHOW: row=~(1<<idx); col=shadow[idx]. The timer loads DWELL_CYCLES-1 on entry.
//    At 0: if idx!=0, decrement idx and go to BLANK; if idx==0, go to LATCH.
//  - Scan order is 7,6,...,0. The row index wraps by re-entering LATCH, never by arithmetic wrap.
//  - Frame period = 1 + 8*(BLANK_CYCLES+DWELL_CYCLES) clocks.
//  - Input changes during a frame are invisible until the next LATCH (no tearing).
//  - enable_InLow sampled 1 in any non-IDLE state: go to IDLE next cycle, outputs dark immediately
//    from that cycle. Shadow rows are retained but not shown. Re-enable always starts with LATCH.
//  - Asynchronous reset mid-frame: outputs go to reset values at once; no frameStart pulse.
//  - enable_InLow=0 while in LATCH: the frame proceeds normally.
//  - Timer width = $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1).
//  - row_OutBUS never has more than one bit low.
// STRUCTURE
//  - Package sc_scan_pkg holds:
//    - state localparams IDLE=2'd0, LATCH=2'd1, BLANK=2'd2, SHOW=2'd3;
//    - NUM_ROWS=8 and ROW_OFF=8'hFF.
//  - One sub-module, sc_scan_timer: a parameterised down-counter with load, load value, and a done flag
//    (count==0). It is instantiated once and reloaded on each BLANK/SHOW entry.
//  - The top level holds the FSM, the 8x8 shadow array, the row index, and the output registers.
// TESTING  (DWELL_CYCLES=4, BLANK_CYCLES=2, so frame = 49 clocks)
//  1. Reset, then hold enable_InLow=1 for 20 clocks -> row=FF, col=00, frameStart=0 throughout.
//  2. data7..0 = 81,42,24,18,18,24,42,81; enable=0 ->
//     - frameStart high 2 clocks after enable is applied;
//     - then row=FF for 2 clocks, then row=7F with col=81 for 4 clocks;
//     - ... down to row=FE with col=81;
//     - next frameStart exactly 49 clocks after the first.
//  3. Change data7 to FF during row 5 of a frame ->
//     - rest of the frame still shows the old values;
//     - next frame shows row=7F with col=FF.
//  4. Raise enable_InLow during SHOW of row 3 ->
//     - next clock row=FF, col=00, state IDLE;
//     - lower it again -> a new frameStart, and the scan restarts at row 7.
//  5. Pulse RESET_InLow low for 1 clock mid-BLANK -> outputs at reset values in the same cycle;
//     after release with enable=0 -> frameStart follows 2 clocks later.
//  6. Assertion over 10 frames: row_OutBUS is always FF or has exactly one zero bit.

Source files
------------

// File: rtl/sc_scan_pkg.sv
// Shared types and constants for the environment matrix scanner.
package sc_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        BLANK = 2'd2,
        SHOW  = 2'd3
    } state_e;

    localparam int unsigned NUM_ROWS  = 8;
    localparam int unsigned ROW_IDX_W = $clog2(NUM_ROWS);
    localparam logic [NUM_ROWS-1:0] ROW_OFF = 8'hFF;

    // Active-low one-hot row select for a given row index.
    function automatic logic [NUM_ROWS-1:0] row_sel(input logic [ROW_IDX_W-1:0] idx);
        return ~(NUM_ROWS'(1) << idx);
    endfunction

endpackage

// File: rtl/sc_scan_timer.sv
// Loadable down-counter that parks at zero; done is combinational (count == 0).
module sc_scan_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             done_c_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: load has priority, otherwise count down and hold at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_c_o = (count_q == '0);

endmodule

// File: rtl/sc_environment_scanner.sv
// Snapshots the eight environment rows once per frame and scans them onto an 8x8 LED matrix.
module sc_environment_scanner
    import sc_scan_pkg::*;
#(
    parameter int unsigned DATAWIDTH    = 8,
    parameter int unsigned DWELL_CYCLES = 2500,
    parameter int unsigned BLANK_CYCLES = 50
) (
    input  logic                 SC_ENVIRONMENT_SCANNER_CLOCK_50,
    input  logic                 SC_ENVIRONMENT_SCANNER_RESET_InLow,
    input  logic                 SC_ENVIRONMENT_SCANNER_enable_InLow,
    input  logic [DATAWIDTH-1:0] SC_ENVIRONMENT_SCANNER_data7_InBUS,
    input  logic [DATAWIDTH-1:0] SC_ENVIRONMENT_SCANNER_data6_InBUS,
    input  logic [DATAWIDTH-1:0] SC_ENVIRONMENT_SCANNER_data5_InBUS,
    input  logic [DATAWIDTH-1:0] SC_ENVIRONMENT_SCANNER_data4_InBUS,
    input  logic [DATAWIDTH-1:0] SC_ENVIRONMENT_SCANNER_data3_InBUS,
    input  logic [DATAWIDTH-1:0] SC_ENVIRONMENT_SCANNER_data2_InBUS,
    input  logic [DATAWIDTH-1:0] SC_ENVIRONMENT_SCANNER_data1_InBUS,
    input  logic [DATAWIDTH-1:0] SC_ENVIRONMENT_SCANNER_data0_InBUS,
    output logic [NUM_ROWS-1:0]  SC_ENVIRONMENT_SCANNER_row_OutBUS,
    output logic [DATAWIDTH-1:0] SC_ENVIRONMENT_SCANNER_col_OutBUS,
    output logic                 SC_ENVIRONMENT_SCANNER_frameStart_Out
);

    localparam int unsigned MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned TMR_W      = $clog2(MAX_CYCLES + 1);

    logic                 clk;
    logic                 rst_n;
    logic                 disable_in;
    logic [DATAWIDTH-1:0] data_in [NUM_ROWS];

    state_e               state_q;
    state_e               state_d;
    logic [ROW_IDX_W-1:0] idx_q;
    logic [ROW_IDX_W-1:0] idx_d;
    logic [DATAWIDTH-1:0] shadow_q [NUM_ROWS];
    logic [DATAWIDTH-1:0] shadow_d [NUM_ROWS];
    logic [NUM_ROWS-1:0]  row_q;
    logic [NUM_ROWS-1:0]  row_d;
    logic [DATAWIDTH-1:0] col_q;
    logic [DATAWIDTH-1:0] col_d;
    logic                 frame_start_q;
    logic                 frame_start_d;

    logic                 tmr_load;
    logic [TMR_W-1:0]     tmr_val;
    logic                 tmr_done_c;

    assign clk        = SC_ENVIRONMENT_SCANNER_CLOCK_50;
    assign rst_n      = SC_ENVIRONMENT_SCANNER_RESET_InLow;
    assign disable_in = SC_ENVIRONMENT_SCANNER_enable_InLow;

    assign data_in[7] = SC_ENVIRONMENT_SCANNER_data7_InBUS;
    assign data_in[6] = SC_ENVIRONMENT_SCANNER_data6_InBUS;
    assign data_in[5] = SC_ENVIRONMENT_SCANNER_data5_InBUS;
    assign data_in[4] = SC_ENVIRONMENT_SCANNER_data4_InBUS;
    assign data_in[3] = SC_ENVIRONMENT_SCANNER_data3_InBUS;
    assign data_in[2] = SC_ENVIRONMENT_SCANNER_data2_InBUS;
    assign data_in[1] = SC_ENVIRONMENT_SCANNER_data1_InBUS;
    assign data_in[0] = SC_ENVIRONMENT_SCANNER_data0_InBUS;

    sc_scan_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_c_o   (tmr_done_c)
    );

    // Next state, row index, snapshot, timer reload and the output values for the next cycle.
    // Outputs are computed from the next state so they line up with the state they belong to.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        shadow_d      = shadow_q;
        tmr_load      = 1'b0;
        tmr_val       = '0;
        row_d         = ROW_OFF;
        col_d         = '0;
        frame_start_d = 1'b0;

        // The snapshot is taken on the edge that ends the LATCH cycle.
        if (state_q == LATCH) begin
            shadow_d = data_in;
        end

        if ((state_q != IDLE) && disable_in) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!disable_in) begin
                        state_d = LATCH;
                    end
                end
                LATCH: begin
                    state_d = BLANK;
                end
                BLANK: begin
                    if (tmr_done_c) begin
                        state_d = SHOW;
                    end
                end
                SHOW: begin
                    if (tmr_done_c) begin
                        if (idx_q != '0) begin
                            idx_d   = idx_q - ROW_IDX_W'(1);
                            state_d = BLANK;
                        end else begin
                            state_d = LATCH;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Every frame restarts at the top row.
        if (state_d == LATCH) begin
            idx_d = ROW_IDX_W'(NUM_ROWS - 1);
        end

        // Reload the timer on entry to a timed state.
        if (state_d != state_q) begin
            if (state_d == BLANK) begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(BLANK_CYCLES - 1);
            end else if (state_d == SHOW) begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(DWELL_CYCLES - 1);
            end
        end

        if (state_d == SHOW) begin
            row_d = row_sel(idx_d);
        end
        if ((state_d == BLANK) || (state_d == SHOW)) begin
            col_d = shadow_d[idx_d];
        end
        frame_start_d = (state_d == LATCH);
    end

    // State, snapshot and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= ROW_IDX_W'(NUM_ROWS - 1);
            for (int i = 0; i < NUM_ROWS; i++) begin
                shadow_q[i] <= '0;
            end
            row_q         <= ROW_OFF;
            col_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            row_q         <= row_d;
            col_q         <= col_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign SC_ENVIRONMENT_SCANNER_row_OutBUS     = row_q;
    assign SC_ENVIRONMENT_SCANNER_col_OutBUS     = col_q;
    assign SC_ENVIRONMENT_SCANNER_frameStart_Out = frame_start_q;

endmodule
